// File: rtl/bitonic_seq_ctrl.sv
// bitonic_seq_ctrl
//   Block-at-a-time bitonic sorter. Loads N elements into a local buffer,
//   sorts them in place with a sequential bitonic network (one
//   compare-exchange issued per cycle, one registered stage), then streams
//   the sorted block out with a valid/ready handshake. Only one block is in
//   flight at a time.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : input element offered
//   in_data    : input element (unsigned)
//   in_dir     : sort direction (0 ascending, 1 descending), taken from the
//                first accepted beat of a block
//   in_ready   : block accepts an input beat this cycle
//   out_valid  : sorted element presented
//   out_data   : sorted element
//   out_last   : final element of the block
//   out_ready  : downstream accepts out_data this cycle
//   busy       : sorting or draining
//
// State | Meaning
// ------+-----------------------------------------------------------
// LOAD  | accepting N input beats into elem_q[0..N-1]
// SORT  | running bitonic passes; each pass = N/2 issues + 1 bubble
// DRAIN | presenting elem_q[rd_idx] until all N beats handshake

module bitonic_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_dir,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int LOG2N = $clog2(N);
  localparam int KW    = $clog2(LOG2N + 1);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] HALF     = LOG2N'(N / 2);
  localparam logic [KW-1:0]    KL_LAST  = KW'(LOG2N);
  localparam logic [LOG2N-1:0] ONE_IDX  = LOG2N'(1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] elem_q [N];

  logic [LOG2N-1:0] wr_idx;
  logic [LOG2N-1:0] rd_idx;
  logic             dir_q;

  // Pass sequencing: k = 2^k_log, j = 2^j_log. slot_cnt counts the issue
  // slots of the current pass down from N/2; the terminal value 0 is the
  // bubble slot that lets the last writeback land before the next pass.
  logic [LOG2N-1:0] slot_cnt;
  logic [KW-1:0]    k_log;
  logic [KW-1:0]    j_log;

  logic                  pipe_vld;
  logic [LOG2N-1:0]      pipe_i;
  logic [LOG2N-1:0]      pipe_l;
  logic [DATA_WIDTH-1:0] pipe_i_val;
  logic [DATA_WIDTH-1:0] pipe_l_val;

  logic load_beat;
  logic load_done;
  logic drain_beat;
  logic issue;
  logic pass_end;
  logic last_pass;

  logic [LOG2N-1:0]      pair_num;
  logic [LOG2N-1:0]      low_mask;
  logic [LOG2N-1:0]      issue_i;
  logic [LOG2N-1:0]      issue_l;
  logic [LOG2N-1:0]      k_bit;
  logic                  pair_asc;
  logic [DATA_WIDTH-1:0] val_i;
  logic [DATA_WIDTH-1:0] val_l;
  logic                  do_swap;

  // ---------------------------------------------------------------------
  // Handshake qualifiers and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready   = (state_q == LOAD) && !rst;
    out_valid  = (state_q == DRAIN);
    out_data   = out_valid ? elem_q[rd_idx] : '0;
    out_last   = out_valid && (rd_idx == LAST_IDX);
    busy       = (state_q != LOAD);

    load_beat  = in_valid && in_ready;
    load_done  = load_beat && (wr_idx == LAST_IDX);
    drain_beat = out_valid && out_ready;

    issue      = (state_q == SORT) && (slot_cnt != '0);
    pass_end   = (state_q == SORT) && (slot_cnt == '0);
    last_pass  = (j_log == '0) && (k_log == KL_LAST);
  end

  // ---------------------------------------------------------------------
  // Pair generation: the pair_num-th index with bit j clear, ascending, is
  // pair_num with a zero inserted at bit position j_log.
  // ---------------------------------------------------------------------
  always_comb begin
    pair_num = HALF - slot_cnt;
    low_mask = ~({LOG2N{1'b1}} << j_log);
    issue_i  = ((pair_num & ~low_mask) << 1) | (pair_num & low_mask);
    issue_l  = issue_i | (ONE_IDX << j_log);
    // k_bit shifts out to zero on the final merge (k = N), so every pair of
    // that merge follows dir_q directly.
    k_bit    = ONE_IDX << k_log;
    pair_asc = ((issue_i & k_bit) == '0) ^ dir_q;

    val_i    = elem_q[issue_i];
    val_l    = elem_q[issue_l];
    do_swap  = pair_asc ? (val_l < val_i) : (val_i < val_l);
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (load_done) begin
          state_d = SORT;
        end
      end
      SORT: begin
        if (pass_end && last_pass) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_beat && (rd_idx == LAST_IDX)) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Counters and control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      dir_q    <= 1'b0;
      slot_cnt <= '0;
      k_log    <= '0;
      j_log    <= '0;
      pipe_vld <= 1'b0;
    end else begin
      pipe_vld <= issue;

      // Indices wrap naturally since N is a power of two, so both return
      // to 0 on the last beat of their phase.
      if (load_beat) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_idx == '0) begin
          dir_q <= in_dir;
        end
      end

      if (drain_beat) begin
        rd_idx <= rd_idx + 1'b1;
      end

      if (load_done) begin
        slot_cnt <= HALF;
        k_log    <= KW'(1);
        j_log    <= '0;
      end else if (state_q == SORT) begin
        if (slot_cnt != '0) begin
          slot_cnt <= slot_cnt - 1'b1;
        end else if (last_pass) begin
          slot_cnt <= '0;
          k_log    <= '0;
          j_log    <= '0;
        end else begin
          slot_cnt <= HALF;
          if (j_log == '0) begin
            // Next merge size: k doubles and j restarts at k/2.
            k_log <= k_log + 1'b1;
            j_log <= k_log;
          end else begin
            j_log <= j_log - 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Element buffer and compare-exchange stage (no reset needed). Pairs
  // within a pass are disjoint, so a writeback never collides with the
  // read issued in the same cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load_beat) begin
      elem_q[wr_idx] <= in_data;
    end

    if (issue) begin
      pipe_i     <= issue_i;
      pipe_l     <= issue_l;
      pipe_i_val <= do_swap ? val_l : val_i;
      pipe_l_val <= do_swap ? val_i : val_l;
    end

    if (pipe_vld) begin
      elem_q[pipe_i] <= pipe_i_val;
      elem_q[pipe_l] <= pipe_l_val;
    end
  end

endmodule

// File: tb/tb_bitonic_seq_ctrl.sv
module tb_bitonic_seq_ctrl;

  localparam int DW       = 32;
  localparam int N        = 8;
  localparam int LG       = $clog2(N);
  localparam int PASSES   = LG * (LG + 1) / 2;
  localparam int SORT_CYC = PASSES * (N / 2 + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_dir;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          busy;

  always #5 clk = ~clk;

  bitonic_seq_ctrl #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: phase (0 load, 1 sort, 2 drain), collected block,
  // fully sorted copy, remaining sort cycles and drain position.
  // ------------------------------------------------------------------
  int            m_mode = 0;
  int            m_cnt  = 0;
  int            m_left = 0;
  int            m_rd   = 0;
  logic          m_dir  = 1'b0;
  logic [DW-1:0] m_blk    [N];
  logic [DW-1:0] m_sorted [N];

  function automatic void model_sort();
    logic [DW-1:0] key;
    int            j;
    for (int i = 0; i < N; i++) m_sorted[i] = m_blk[i];
    for (int i = 1; i < N; i++) begin
      key = m_sorted[i];
      j   = i - 1;
      while (j >= 0 && (m_dir ? (m_sorted[j] < key) : (m_sorted[j] > key))) begin
        m_sorted[j+1] = m_sorted[j];
        j--;
      end
      m_sorted[j+1] = key;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0;
      m_cnt  = 0;
      m_rd   = 0;
      m_left = 0;
    end else begin
      case (m_mode)
        0: if (in_valid) begin
          if (m_cnt == 0) m_dir = in_dir;
          m_blk[m_cnt] = in_data;
          m_cnt++;
          if (m_cnt == N) begin
            model_sort();
            m_cnt  = 0;
            m_left = SORT_CYC;
            m_mode = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = 2;
            m_rd   = 0;
          end
        end
        default: if (out_ready) begin
          m_rd++;
          if (m_rd == N) begin
            m_rd   = 0;
            m_mode = 0;
          end
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Compare process (falling edge) plus capture of accepted output beats.
  // A beat presented at one falling edge is taken at the next rising edge
  // if out_ready is high, which is still visible at the next falling edge.
  // ------------------------------------------------------------------
  logic [DW-1:0] capq[$];
  logic          prev_valid = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always @(negedge clk) begin
    chk("in_ready",  in_ready,  (m_mode == 0) && !rst);
    chk("out_valid", out_valid, m_mode == 2);
    chk("busy",      busy,      m_mode != 0);
    chk("out_last",  out_last,  (m_mode == 2) && (m_rd == N - 1));
    chk("out_data",  out_data,  (m_mode == 2) ? m_sorted[m_rd] : '0);
    if (!rst && prev_valid && out_ready) capq.push_back(prev_data);
    prev_valid = out_valid;
    prev_data  = out_data;
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  int phase;

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_idle(input int rmode, input bit hold);
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = (phase % 3 == 0);
      default: out_ready = $urandom_range(0, 1);
    endcase
    in_valid = hold;
    if (hold) in_data = $urandom;
    phase++;
  endtask

  task automatic pulse_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // abort_sort >= 0: reset after that many sort cycles.
  // abort_drain >= 0: reset after that many drain cycles.
  task automatic run_block(input logic [DW-1:0] v [N], input bit d, input int rmode,
                           input bit hold, input int abort_sort, input int abort_drain);
    int lat;
    int n;
    capq.delete();
    phase = 0;
    for (int e = 0; e < N; e++) begin
      if (rmode == 2 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        cycle();
      end
      in_valid = 1'b1;
      in_data  = v[e];
      in_dir   = (e == 0) ? d : 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid = hold;

    lat = 0;
    while (!out_valid && lat < 200) begin
      if (lat == abort_sort) begin
        pulse_reset();
        return;
      end
      drive_idle(rmode, hold);
      cycle();
      lat++;
    end
    chk("sort_latency", lat, SORT_CYC);

    phase = 0;
    n     = 0;
    while (!in_ready && n < 400) begin
      if (n == abort_drain) begin
        pulse_reset();
        return;
      end
      drive_idle(rmode, hold);
      cycle();
      n++;
    end
    chk("drain_done", in_ready, 1'b1);
    chk("out_count", capq.size(), N);
    in_valid = hold;
  endtask

  task automatic chk_out(input string name, input logic [DW-1:0] exp [N]);
    for (int i = 0; i < N; i++) begin
      if (i < capq.size()) chk(name, capq[i], exp[i]);
      else                 chk(name, 32'hDEAD_BEEF, exp[i]);
    end
  endtask

  logic [DW-1:0] blk [N];
  logic [DW-1:0] expv [N];
  logic [DW-1:0] base [N];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    phase     = 0;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    base = '{5, 3, 7, 1, 8, 2, 6, 4};

    // Ascending, always ready.
    run_block(base, 1'b0, 0, 1'b0, -1, -1);
    expv = '{1, 2, 3, 4, 5, 6, 7, 8};
    chk_out("asc_out", expv);

    // Descending.
    run_block(base, 1'b1, 0, 1'b0, -1, -1);
    expv = '{8, 7, 6, 5, 4, 3, 2, 1};
    chk_out("desc_out", expv);

    // Duplicates.
    blk = '{4, 4, 1, 1, 4, 1, 0, 0};
    run_block(blk, 1'b0, 0, 1'b0, -1, -1);
    expv = '{0, 0, 1, 1, 1, 4, 4, 4};
    chk_out("dup_out", expv);

    // Stalled drain with ready pattern 1,0,0,...
    run_block(base, 1'b0, 1, 1'b0, -1, -1);
    expv = '{1, 2, 3, 4, 5, 6, 7, 8};
    chk_out("stall_out", expv);

    // Reset in sort cycle 12, then a fresh block.
    run_block(base, 1'b1, 0, 1'b0, 12, -1);
    cycle();
    blk = '{9, 0, 0, 0, 0, 0, 0, 0};
    run_block(blk, 1'b0, 0, 1'b0, -1, -1);
    expv = '{0, 0, 0, 0, 0, 0, 0, 9};
    chk_out("post_rst_out", expv);

    // in_valid held through sort and drain with changing data.
    for (int i = 0; i < N; i++) blk[i] = $urandom;
    run_block(blk, 1'b0, 2, 1'b1, -1, -1);
    run_block(base, 1'b0, 0, 1'b0, -1, -1);
    expv = '{1, 2, 3, 4, 5, 6, 7, 8};
    chk_out("after_hold_out", expv);

    // Reset mid-drain, then recovery.
    run_block(base, 1'b0, 1, 1'b0, -1, 4);
    cycle();
    run_block(base, 1'b1, 2, 1'b0, -1, -1);
    expv = '{8, 7, 6, 5, 4, 3, 2, 1};
    chk_out("post_drain_rst_out", expv);

    // Randomized blocks; the per-cycle compare checks them against the model.
    for (int b = 0; b < 14; b++) begin
      for (int i = 0; i < N; i++)
        blk[i] = (b % 2 == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom);
      run_block(blk, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, SORT_CYC - 1) : -1, -1);
      in_valid = 1'b0;
      if (rst) cycle();
    end

    repeat (3) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
